// File: rtl/uart_alu_interface.sv
// uart_alu_interface: loads operand A, operand B and the opcode from three
// consecutive UART bytes, lets the ALU settle for one cycle, captures the
// result and hands it to the UART transmitter.
//
// Handshake: i_rx_done and i_tx_done are single-cycle pulses, and the FSM
// samples them only in the states that expect them; a pulse seen anywhere
// else is dropped. o_tx_start is a single-cycle request. o_tx_data is held
// from the o_tx_start cycle until i_tx_done closes the transfer, and it stays
// held after that until the next result overwrites it.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_RESULT  = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   operation_q, operation_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;

    // State and held registers; reset abandons any transfer in progress.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_WAIT_A;
            data_a_q    <= '0;
            data_b_q    <= '0;
            operation_q <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            operation_q <= operation_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Next state and register loads; every register holds by default.
    always_comb begin
        state_d     = state_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        operation_d = operation_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d = i_rx_data;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    data_b_d = i_rx_data;
                    state_d  = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    // Only the low bits carry the opcode; the rest is discarded.
                    operation_d = i_rx_data[NB_OP-1:0];
                    state_d     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                // All ALU inputs have been registered for a full cycle now.
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A simultaneous rx byte is dropped along with the return.
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                // Unused encodings recover to the idle state.
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // Outputs come only from registers or a decode of the state register.
    always_comb begin
        o_tx_start  = (state_q == ST_SEND);
        o_busy      = (state_q == ST_RESULT) || (state_q == ST_SEND) ||
                      (state_q == ST_WAIT_TX);
        o_tx_data   = tx_data_q;
        o_data_a    = data_a_q;
        o_data_b    = data_b_q;
        o_operation = operation_q;
    end

endmodule
